// File: rtl/div_result_bcd.sv
// div_result_bcd
//
// Sits behind the iterative divider. On the rising edge of `stop` it captures
// the quotient and remainder, converts both to packed BCD with a sequential
// double-dabble (one binary bit per clock, N clocks), then presents the pair
// on a valid/ready handshake.
//
// Optional feature: define DIV_RESULT_BCD_INBUF_EN to add a one-entry input
// buffer. A capture that arrives while busy is then held and converted straight
// after the current transfer, with no idle bubble. Without the macro, any
// capture while busy is dropped and flagged on `overrun`.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   quo, rem   divider quotient / remainder (N bits), valid while stop is high
//   stop       divider done; a pulse or a held level
//   out_ready  consumer accepts the result
//   out_valid  quo_bcd/rem_bcd hold a complete result
//   quo_bcd    quotient in BCD (4*DIGITS bits, digit 0 in [3:0])
//   rem_bcd    remainder in BCD, same packing
//   busy       conversion running or result waiting for transfer
//   overrun    sticky: a capture was lost (cleared only by reset)

module div_result_bcd #(
  parameter int N      = 4,
  parameter int DIGITS = (N + 2) / 3,
  parameter int C_BIT  = $clog2(N + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [N-1:0]          quo,
  input  logic [N-1:0]          rem,
  input  logic                  stop,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   quo_bcd,
  output logic [4*DIGITS-1:0]   rem_bcd,
  output logic                  busy,
  output logic                  overrun
);

  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             stop_d;
  logic [C_BIT-1:0] cnt;
  logic [N-1:0]     quo_sh;
  logic [N-1:0]     rem_sh;
  logic [BW-1:0]    quo_acc;
  logic [BW-1:0]    rem_acc;

  logic             cap_event;
  logic             load_new;
  logic             load_pend;
  logic             do_shift;
  logic             ovr_set;

`ifdef DIV_RESULT_BCD_INBUF_EN
  logic             pend_valid;
  logic [N-1:0]     pend_quo;
  logic [N-1:0]     pend_rem;
  logic             pend_store;
`endif

  // One double-dabble step on the BCD accumulator: correct every digit that
  // would overflow past 9 when doubled, then shift in the next binary bit.
  function automatic logic [BW-1:0] dabble_step(input logic [BW-1:0] acc,
                                                input logic          bin_msb);
    logic [BW-1:0] adj;
    adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return (adj << 1) | BW'(bin_msb);
  endfunction

  // A held stop level yields a single event on its first cycle.
  assign cap_event = stop & ~stop_d;
  assign busy      = (state != IDLE);
  assign quo_bcd   = quo_acc;
  assign rem_bcd   = rem_acc;

  always_comb begin
    state_nxt = state;
    load_new  = 1'b0;
    load_pend = 1'b0;
    do_shift  = 1'b0;
    ovr_set   = 1'b0;
`ifdef DIV_RESULT_BCD_INBUF_EN
    pend_store = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (cap_event) begin
          load_new  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        do_shift = 1'b1;
        if (cnt == C_BIT'(1))
          state_nxt = HOLD;
      end
      HOLD: begin
        // out_valid is always high in HOLD, so out_ready alone completes it.
        if (out_ready) begin
          state_nxt = IDLE;
`ifdef DIV_RESULT_BCD_INBUF_EN
          if (pend_valid) begin
            load_pend = 1'b1;
            state_nxt = SHIFT;
          end
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase

    // An event in the transfer cycle still counts as busy: it is never
    // folded into the result leaving this edge.
    if (cap_event && busy) begin
`ifdef DIV_RESULT_BCD_INBUF_EN
      // The buffer may be refilled on the same edge it drains.
      if (!pend_valid || load_pend)
        pend_store = 1'b1;
      else
        ovr_set = 1'b1;
`else
      ovr_set = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      stop_d    <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      quo_acc   <= '0;
      rem_acc   <= '0;
`ifdef DIV_RESULT_BCD_INBUF_EN
      pend_valid <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      stop_d    <= stop;
      out_valid <= (state_nxt == HOLD);
      overrun   <= overrun | ovr_set;
      if (load_new || load_pend) begin
        cnt     <= C_BIT'(N);
        quo_acc <= '0;
        rem_acc <= '0;
      end else if (do_shift) begin
        cnt     <= cnt - C_BIT'(1);
        quo_acc <= dabble_step(quo_acc, quo_sh[N-1]);
        rem_acc <= dabble_step(rem_acc, rem_sh[N-1]);
      end
`ifdef DIV_RESULT_BCD_INBUF_EN
      if (pend_store)
        pend_valid <= 1'b1;
      else if (load_pend)
        pend_valid <= 1'b0;
`endif
    end
  end

  // Binary shift registers and buffered operands carry no reset: they are
  // always loaded before being used.
  always_ff @(posedge clk) begin
    if (load_new) begin
      quo_sh <= quo;
      rem_sh <= rem;
`ifdef DIV_RESULT_BCD_INBUF_EN
    end else if (load_pend) begin
      quo_sh <= pend_quo;
      rem_sh <= pend_rem;
`endif
    end else if (do_shift) begin
      quo_sh <= quo_sh << 1;
      rem_sh <= rem_sh << 1;
    end
`ifdef DIV_RESULT_BCD_INBUF_EN
    if (pend_store) begin
      pend_quo <= quo;
      pend_rem <= rem;
    end
`endif
  end

endmodule

// File: tb/tb_div_result_bcd.sv
// Scoreboard bench for div_result_bcd (N=4 instance plus an N=8 instance).
// Expected BCD pairs are queued when stimulus is issued; monitors pop and
// compare on every handshake.

module tb_div_result_bcd;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] quo = '0;
  logic [3:0] rem = '0;
  logic       stop = 1'b0;
  logic       out_ready = 1'b1;
  logic       out_valid;
  logic [7:0] quo_bcd;
  logic [7:0] rem_bcd;
  logic       busy;
  logic       overrun;

  logic [7:0]  quo8 = '0;
  logic [7:0]  rem8 = '0;
  logic        stop8 = 1'b0;
  logic        out_ready8 = 1'b1;
  logic        out_valid8;
  logic [11:0] quo_bcd8;
  logic [11:0] rem_bcd8;
  logic        busy8;
  logic        overrun8;

  int n_cmp = 0;
  int n_bad = 0;
  int n_res = 0;
  logic [15:0] exp_q[$];
  logic [23:0] exp8[$];

  div_result_bcd #(.N(4)) dut (
    .clk(clk), .reset_n(reset_n), .quo(quo), .rem(rem), .stop(stop),
    .out_ready(out_ready), .out_valid(out_valid), .quo_bcd(quo_bcd),
    .rem_bcd(rem_bcd), .busy(busy), .overrun(overrun)
  );

  div_result_bcd #(.N(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .quo(quo8), .rem(rem8), .stop(stop8),
    .out_ready(out_ready8), .out_valid(out_valid8), .quo_bcd(quo_bcd8),
    .rem_bcd(rem_bcd8), .busy(busy8), .overrun(overrun8)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Event on the first cycle, stop high for len cycles, then one low cycle.
  task automatic pulse(input logic [3:0] q, input logic [3:0] r, input int len);
    quo  = q;
    rem  = r;
    stop = 1'b1;
    repeat (len) tick();
    stop = 1'b0;
    tick();
  endtask

  task automatic wait_valid(input int start, output int lat);
    lat = start;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!out_valid) chk("valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      n_res++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %h/%h expected none", quo_bcd, rem_bcd);
      end else begin
        chk("result", {16'd0, quo_bcd, rem_bcd}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && out_valid8 && out_ready8) begin
      if (exp8.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result8: got %h/%h expected none", quo_bcd8, rem_bcd8);
      end else begin
        chk("result8", {8'd0, quo_bcd8, rem_bcd8}, {8'd0, exp8.pop_front()});
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int res0;

    // Reset state
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_bcd", {16'd0, quo_bcd, rem_bcd}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // 14/4: single-cycle stop pulse, latency and busy window
    exp_q.push_back({8'h03, 8'h02});
    quo = 4'd3; rem = 4'd2; stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t1_busy_c1", {31'd0, busy}, 32'd1);
    chk("t1_valid_c1", {31'd0, out_valid}, 32'd0);
    wait_valid(1, lat);
    chk("t1_latency", lat, 32'd5);
    chk("t1_busy_c5", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_valid_after", {31'd0, out_valid}, 32'd0);
    chk("t1_busy_after", {31'd0, busy}, 32'd0);

    // 13/3: stop held three cycles gives one result
    exp_q.push_back({8'h04, 8'h01});
    pulse(4'd4, 4'd1, 3);
    wait_valid(4, lat);
    chk("t2_latency", lat, 32'd5);
    res0 = n_res;
    repeat (12) tick();
    chk("t2_one_result", n_res - res0, 32'd1);
    chk("t2_overrun", {31'd0, overrun}, 32'd0);

    // 15/1: max value
    exp_q.push_back({8'h15, 8'h00});
    pulse(4'd15, 4'd0, 1);
    wait_valid(2, lat);
    tick();
    chk("t3_busy_after", {31'd0, busy}, 32'd0);

    // N=8 instance: 255 and 200/99
    exp8.push_back({12'h255, 12'h007});
    quo8 = 8'd255; rem8 = 8'd7; stop8 = 1'b1;
    tick();
    stop8 = 1'b0;
    lat = 1;
    while (!out_valid8 && lat < 40) begin tick(); lat++; end
    chk("t8_latency", lat, 32'd9);
    tick();
    exp8.push_back({12'h200, 12'h099});
    quo8 = 8'd200; rem8 = 8'd99; stop8 = 1'b1;
    tick();
    stop8 = 1'b0;
    repeat (12) tick();
    chk("t8_busy", {31'd0, busy8}, 32'd0);
    chk("t8_overrun", {31'd0, overrun8}, 32'd0);

    // Backpressure for 10 cycles with a second event inside the window
    out_ready = 1'b0;
    exp_q.push_back({8'h02, 8'h03});
`ifdef DIV_RESULT_BCD_INBUF_EN
    exp_q.push_back({8'h07, 8'h01});
`endif
    pulse(4'd2, 4'd3, 1);
    wait_valid(2, lat);
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_hold_data", {16'd0, quo_bcd, rem_bcd}, 32'h0203);
      if (i == 2) begin
        quo = 4'd7; rem = 4'd1; stop = 1'b1;
      end else begin
        stop = 1'b0;
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
`ifdef DIV_RESULT_BCD_INBUF_EN
    chk("t4_overrun_on", {31'd0, overrun}, 32'd0);
    wait_valid(1, lat);
    chk("t4_b2b_latency", lat, 32'd5);
    tick();
`else
    chk("t4_overrun_off", {31'd0, overrun}, 32'd1);
    chk("t4_valid_off", {31'd0, out_valid}, 32'd0);
    chk("t4_busy_off", {31'd0, busy}, 32'd0);
`endif

    // Reset during SHIFT cycle 2 discards the conversion
    quo = 4'd5; rem = 4'd4; stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    chk("t5_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_overrun", {31'd0, overrun}, 32'd0);
    chk("t5_bcd", {16'd0, quo_bcd, rem_bcd}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();
    exp_q.push_back({8'h03, 8'h01});
    pulse(4'd3, 4'd1, 1);
    wait_valid(2, lat);
    chk("t5_latency", lat, 32'd5);
    tick();

    // Three events while busy
    out_ready = 1'b0;
    exp_q.push_back({8'h01, 8'h02});
`ifdef DIV_RESULT_BCD_INBUF_EN
    exp_q.push_back({8'h06, 8'h03});
`endif
    pulse(4'd1, 4'd2, 1);
    pulse(4'd6, 4'd3, 1);
    pulse(4'd9, 4'd0, 1);
    chk("t6_overrun", {31'd0, overrun}, 32'd1);
    res0 = n_res;
    out_ready = 1'b1;
    repeat (20) tick();
`ifdef DIV_RESULT_BCD_INBUF_EN
    chk("t6_results", n_res - res0, 32'd2);
`else
    chk("t6_results", n_res - res0, 32'd1);
`endif
    chk("t6_busy", {31'd0, busy}, 32'd0);

    chk("queue_empty", exp_q.size(), 32'd0);
    chk("queue8_empty", exp8.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
